send_queue_drainer: RTL and testbench
=====================================

SEND_QUEUE_DRAINER -- requirements
Module: send_queue_drainer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter QUEUE_LOG, default 9, pointer width; queue depth is 2**QUEUE_LOG = 512 bytes.
REQ-003 Design uses one clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1  system clock; all state changes on its rising edge.
REQ-005 INITIALIZE_N  input  1  asynchronous active-low reset.
REQ-006 queue_t  input  QUEUE_LOG  producer write pointer; slot queue_t is the next one the CPU fills.
REQ-007 rd_data  input  8  byte stored at send_queue[rd_addr]; combinational read.
REQ-008 rd_addr  output  QUEUE_LOG  read address into the send queue.
REQ-009 queue_s  output  QUEUE_LOG  consumer read pointer; slot queue_s is the next byte to transmit.
REQ-010 UART_TX  output  1  serial line, idle high.
REQ-011 LED  output  8  status: [0] busy, [1] queue non-empty, [7:2] count of sent bytes mod 64.

Function
REQ-012 Queue empty SHALL be queue_s == queue_t; the producer treats the queue as full when queue_t+1 == queue_s, so at most 511 bytes are pending.
REQ-013 rd_addr SHALL always equal queue_s.
REQ-014 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-015 IDLE: UART_TX=1; if not empty, latch rd_data into a shift register, increment queue_s modulo 2**QUEUE_LOG, clear the bit timer and go to START, all in the same cycle.
REQ-016 START: UART_TX=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-017 DATA: drive shift-register bit 0 (LSB first) for CLKS_PER_BIT cycles per bit, shift right after each bit; after bit index 7, go to STOP.
REQ-018 STOP: UART_TX=1 for CLKS_PER_BIT cycles, increment the sent-byte counter, then return to IDLE.
REQ-019 A frame SHALL occupy exactly 10*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
REQ-020 Back-to-back bytes SHALL be separated by exactly one IDLE cycle of UART_TX=1.
REQ-021 UART_TX SHALL be driven from a flop and be glitch-free.
REQ-022 queue_s SHALL wrap from 2**QUEUE_LOG-1 to 0 with no special handling.
REQ-023 queue_t changing in the same cycle as IDLE samples it: the registered (pre-edge) value SHALL be used, and the new byte is taken on a later IDLE cycle.
REQ-024 The block SHALL never read or modify a slot other than send_queue[queue_s].
REQ-025 queue_t is sampled only in IDLE; changes during a frame SHALL NOT affect that frame.
REQ-026 LED[0] SHALL be 1 in START, DATA and STOP; LED[1] SHALL be (queue_s != queue_t).

Reset
REQ-027 Asserting INITIALIZE_N low SHALL immediately force state=IDLE, UART_TX=1, queue_s=0, bit timer=0, bit index=0, shift register=0, sent counter=0, and LED=0.
REQ-028 Reset mid-frame SHALL abort the frame with no stop bit; the producer is also reset, so pending bytes are discarded.
REQ-029 After deassertion, the first transmission SHALL start no earlier than the second rising edge of CLK.

Structure
REQ-030 The state enum (IDLE/START/DATA/STOP) and the default baud constant SHALL live in the shared cpu_pkg package.
REQ-031 The bit timer SHALL be one sub-module, uart_bit_timer: a counter with clear input and a tick output every CLKS_PER_BIT cycles.
REQ-032 The implementation SHALL contain no inferred latches and use no multicycle paths.

Verification (CLKS_PER_BIT=4)
REQ-033 Single byte: after reset, put 0x41 at slot 0 and set queue_t=1 -> UART_TX shows 0,1,0,0,0,0,0,1,0,1 with each bit 4 cycles wide; queue_s=1 one cycle after queue_t rises; LED[7:2]=1.
REQ-034 Burst: 3 bytes 0x00, 0xFF, 0x55 written at once -> three frames, each 40 cycles, with exactly 1 idle cycle between frames; queue_s ends at 3.
REQ-035 Wrap-around: queue_s=queue_t=510, then push 4 bytes -> bytes sent in order from slots 510, 511, 0, 1; queue_s ends at 2.
REQ-036 Full queue: producer fills 511 bytes while the first is in flight -> all 511 bytes are transmitted in order, none lost; LED[1] falls after the last latch.
REQ-037 Reset mid-frame: assert INITIALIZE_N low during DATA bit 3 -> UART_TX=1 in the same cycle; queue_s=0 and LED=0; no further transmission until queue_t changes.
REQ-038 Sampling race: queue_t increments on the same edge at which IDLE checks it -> the byte starts one cycle later, with a correct frame.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: UART transmitter state encoding and default baud divisor.
package cpu_pkg;
    // 100 MHz system clock, 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;
endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter; tick_o marks the last cycle of each CLKS_PER_BIT window.
module uart_bit_timer
    import cpu_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic tick_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/send_queue_drainer.sv
// Drains the CPU send queue byte by byte onto an 8N1 UART line, LSB first.
module send_queue_drainer
    import cpu_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int QUEUE_LOG    = 9
) (
    input  logic                 CLK,
    input  logic                 INITIALIZE_N,
    input  logic [QUEUE_LOG-1:0] queue_t,
    input  logic [7:0]           rd_data,
    output logic [QUEUE_LOG-1:0] rd_addr,
    output logic [QUEUE_LOG-1:0] queue_s,
    output logic                 UART_TX,
    output logic [7:0]           LED
);
    tx_state_e            state_q, state_d;
    logic [7:0]           shreg_q, shreg_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [QUEUE_LOG-1:0] qs_q, qs_d;
    logic [5:0]           sent_q, sent_d;
    logic                 tx_q, tx_d;
    logic                 armed_q;
    logic                 timer_clr;
    logic                 tick;
    logic                 empty;

    assign empty   = (qs_q == queue_t);
    assign rd_addr = qs_q;
    assign queue_s = qs_q;
    assign UART_TX = tx_q;
    assign LED     = {sent_q, ~empty, (state_q != IDLE)};

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i  (CLK),
        .rst_ni (INITIALIZE_N),
        .clear_i(timer_clr),
        .tick_o (tick)
    );

    // tx_d is the line level for the state being entered, so UART_TX comes straight off a flop
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        qs_d      = qs_q;
        sent_d    = sent_q;
        tx_d      = tx_q;
        timer_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                timer_clr = 1'b1;
                tx_d      = 1'b1;
                if (armed_q && !empty) begin
                    shreg_d = rd_data;
                    qs_d    = qs_q + 1'b1;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shreg_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = shreg_q[1];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    sent_d  = sent_q + 1'b1;
                    tx_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // armed_q holds off the first latch until the second edge after reset release
    always_ff @(posedge CLK or negedge INITIALIZE_N) begin
        if (!INITIALIZE_N) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            qs_q      <= '0;
            sent_q    <= '0;
            tx_q      <= 1'b1;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            qs_q      <= qs_d;
            sent_q    <= sent_d;
            tx_q      <= tx_d;
            armed_q   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_send_queue_drainer.sv
// Bench for send_queue_drainer: byte scoreboard checked by a UART frame monitor.
module tb_send_queue_drainer;
    localparam int CPB = 4;
    localparam int QL  = 9;
    localparam int FRAME = 10 * CPB + 1;

    logic          CLK;
    logic          INITIALIZE_N;
    logic [QL-1:0] queue_t;
    logic [7:0]    rd_data;
    logic [QL-1:0] rd_addr;
    logic [QL-1:0] queue_s;
    logic          UART_TX;
    logic [7:0]    LED;

    logic [7:0] mem [0:(1<<QL)-1];
    logic [7:0] sb[$];
    int         start_q[$];
    int         cyc;
    logic       busy_mon;
    int         checks;
    int         errors;

    typedef struct {
        logic [7:0] data;
        logic [5:0] cnt;
    } vec_t;
    vec_t vecs[4];

    send_queue_drainer #(
        .CLKS_PER_BIT(CPB),
        .QUEUE_LOG   (QL)
    ) dut (
        .CLK         (CLK),
        .INITIALIZE_N(INITIALIZE_N),
        .queue_t     (queue_t),
        .rd_data     (rd_data),
        .rd_addr     (rd_addr),
        .queue_s     (queue_s),
        .UART_TX     (UART_TX),
        .LED         (LED)
    );

    assign rd_data = mem[rd_addr];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[queue_t] = b;
        sb.push_back(b);
        queue_t = queue_t + 9'd1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        INITIALIZE_N = 1'b0;
        queue_t = '0;
        sb.delete();
        repeat (3) @(negedge CLK);
        INITIALIZE_N = 1'b1;
        repeat (3) @(negedge CLK);
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n;
        n = 0;
        @(negedge CLK);
        while ((sb.size() != 0 || busy_mon || LED[0] !== 1'b0) && n < max_cyc) begin
            @(negedge CLK);
            n++;
        end
        check({name, "_drained"}, 32'(n < max_cyc), 32'd1);
    endtask

    // UART receiver: checks every cycle of each frame against the next scoreboard byte
    initial begin : monitor
        logic [7:0] exp_b, got_b;
        logic       bad, aborted, have_exp, exp_bit;
        busy_mon = 1'b0;
        forever begin
            @(negedge CLK);
            if (INITIALIZE_N === 1'b1 && UART_TX === 1'b0) begin
                busy_mon = 1'b1;
                start_q.push_back(cyc);
                have_exp = (sb.size() != 0);
                exp_b = 8'h00;
                if (have_exp) exp_b = sb.pop_front();
                bad = 1'b0;
                aborted = 1'b0;
                got_b = '0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int c = 0; c < CPB && !aborted; c++) begin
                        if (b != 0 || c != 0) @(negedge CLK);
                        if (INITIALIZE_N !== 1'b1) begin
                            aborted = 1'b1;
                        end else begin
                            exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_b[b-1];
                            if (UART_TX !== exp_bit) bad = 1'b1;
                            if (c == CPB / 2 && b >= 1 && b <= 8) got_b[b-1] = UART_TX;
                        end
                    end
                end
                if (!aborted) begin
                    if (!have_exp) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got byte 0x%0h with empty scoreboard", got_b);
                    end else begin
                        check("frame", {23'd0, bad, got_b}, {23'd0, 1'b0, exp_b});
                    end
                end
                busy_mon = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lows;
        logic [QL-1:0] qs_before;
        checks = 0;
        errors = 0;
        for (int i = 0; i < (1 << QL); i++) mem[i] = 8'h00;
        vecs[0] = '{8'hA5, 6'd2};
        vecs[1] = '{8'h3C, 6'd3};
        vecs[2] = '{8'h80, 6'd4};
        vecs[3] = '{8'h01, 6'd5};

        queue_t = '0;
        INITIALIZE_N = 1'b1;
        #2 INITIALIZE_N = 1'b0;
        #1;
        check("rst_uart_tx", 32'(UART_TX), 32'd1);
        check("rst_queue_s", 32'(queue_s), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_led", 32'(LED), 32'd0);
        repeat (3) @(negedge CLK);
        INITIALIZE_N = 1'b1;
        repeat (3) @(negedge CLK);

        // single byte 0x41
        @(posedge CLK); #1;
        push(8'h41);
        @(posedge CLK); #1;
        check("single_queue_s", 32'(queue_s), 32'd1);
        check("single_busy", 32'(LED[0]), 32'd1);
        check("single_nonempty", 32'(LED[1]), 32'd0);
        check("single_start_low", 32'(UART_TX), 32'd0);
        wait_drain("single", 2 * FRAME);
        check("single_sent_cnt", 32'(LED[7:2]), 32'd1);

        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            push(vecs[i].data);
            wait_drain("vec", 2 * FRAME);
            check("vec_sent_cnt", 32'(LED[7:2]), 32'(vecs[i].cnt));
            check("vec_queue_s", 32'(queue_s), 32'(queue_t));
            check("vec_idle_line", 32'(UART_TX), 32'd1);
        end

        // reset during DATA bit 3 of 0xF0 (bit 3 is a 0 on the line)
        @(posedge CLK); #1;
        push(8'hF0);
        lows = 0;
        while (UART_TX !== 1'b0 && lows < 20) begin
            @(negedge CLK);
            lows++;
        end
        check("midrst_started", 32'(UART_TX), 32'd0);
        repeat (17) @(negedge CLK);
        check("midrst_bit3_low", 32'(UART_TX), 32'd0);
        #1;
        INITIALIZE_N = 1'b0;
        queue_t = '0;
        sb.delete();
        #1;
        check("midrst_uart_tx", 32'(UART_TX), 32'd1);
        check("midrst_queue_s", 32'(queue_s), 32'd0);
        check("midrst_led", 32'(LED), 32'd0);
        repeat (2) @(negedge CLK);
        INITIALIZE_N = 1'b1;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (UART_TX !== 1'b1) lows++;
        end
        check("midrst_no_tx", 32'(lows), 32'd0);

        // byte pending at release: first latch only on the second edge
        @(negedge CLK);
        INITIALIZE_N = 1'b0;
        repeat (2) @(negedge CLK);
        INITIALIZE_N = 1'b1;
        push(8'h5A);
        @(posedge CLK); #1;
        check("release_edge1_queue_s", 32'(queue_s), 32'd0);
        @(posedge CLK); #1;
        check("release_edge2_queue_s", 32'(queue_s), 32'd1);
        wait_drain("release", 2 * FRAME);

        // queue_t advances on the very edge at which IDLE samples it
        @(posedge CLK);
        mem[queue_t] = 8'hC3;
        sb.push_back(8'hC3);
        qs_before = queue_s;
        queue_t <= queue_t + 9'd1;
        #1;
        check("race_same_edge_queue_s", 32'(queue_s), 32'(qs_before));
        check("race_same_edge_idle", 32'(LED[0]), 32'd0);
        @(posedge CLK); #1;
        check("race_next_edge_queue_s", 32'(queue_s), 32'(qs_before + 9'd1));
        check("race_next_edge_start", 32'(UART_TX), 32'd0);
        wait_drain("race", 2 * FRAME);

        // burst of three with one idle cycle between frames
        do_reset();
        start_q.delete();
        @(posedge CLK); #1;
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        wait_drain("burst", 4 * FRAME);
        check("burst_frames", 32'(start_q.size()), 32'd3);
        if (start_q.size() == 3) begin
            check("burst_gap01", 32'(start_q[1] - start_q[0]), 32'(FRAME));
            check("burst_gap12", 32'(start_q[2] - start_q[1]), 32'(FRAME));
        end
        check("burst_queue_s", 32'(queue_s), 32'd3);

        // 511 bytes queued while the first is in flight
        do_reset();
        @(posedge CLK); #1;
        push(8'h00);
        for (int i = 1; i < 511; i++) begin
            @(posedge CLK); #1;
            push(8'(i * 7 + 3));
        end
        check("full_nonempty", 32'(LED[1]), 32'd1);
        wait_drain("full", 512 * FRAME);
        check("full_queue_s", 32'(queue_s), 32'd511);
        check("full_empty", 32'(LED[1]), 32'd0);
        check("full_sent_cnt", 32'(LED[7:2]), 32'd63);

        // wrap-around from slot 510
        do_reset();
        @(posedge CLK); #1;
        for (int i = 0; i < 510; i++) push(8'(i) ^ 8'h5A);
        wait_drain("prewrap", 512 * FRAME);
        check("prewrap_queue_s", 32'(queue_s), 32'd510);
        @(posedge CLK); #1;
        push(8'hDE);
        push(8'hAD);
        push(8'hBE);
        push(8'hEF);
        wait_drain("wrap", 6 * FRAME);
        check("wrap_queue_s", 32'(queue_s), 32'd2);
        check("wrap_rd_addr", 32'(rd_addr), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
